// File: rtl/gbt_tx_pkg.sv
// Shared types and constants for the GBT return-link frame generator:
// state encoding, framing marks, default words and the PRBS7 definition.
package gbt_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_TRL  = 3'd3,
        ST_TEST = 3'd4
    } state_t;

    localparam logic [7:0]  HDR_MARK      = 8'hA5;
    localparam logic [15:0] DEF_IDLE_WORD = 16'hBC50;
    localparam logic [15:0] DEF_FILL_WORD = 16'hF7F7;

    // Taps for x^7 + x^6 + 1 sit on state bits 6 and 5
    localparam logic [6:0]  PRBS7_POLY    = 7'h60;
    localparam logic [6:0]  PRBS7_SEED    = 7'h7F;

    // Advance PRBS7 by 16 bits; returns {next_state, word}, first bit in the word MSB
    function automatic logic [22:0] prbs7_adv16(input logic [6:0] state);
        logic [6:0]  s;
        logic [15:0] w;
        logic        nb;
        s = state;
        w = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            nb = ^(s & PRBS7_POLY);
            w  = {w[14:0], nb};
            s  = {s[5:0], nb};
        end
        return {s, w};
    endfunction

endpackage

// File: rtl/gbt_tx_frame_gen_sync.sv
// gbt_link_sync: STAGES-deep flip-flop synchronizer for a single
// asynchronous level, cleared by an asynchronous active-low reset.
module gbt_link_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous level through the synchronizer chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/gbt_tx_frame_gen.sv
// GBT return-link frame generator: idle / header / payload / checksum trailer
// framing plus a link test pattern. Macro GBT_TX_PRBS_EN selects PRBS7 test data.
import gbt_tx_pkg::*;

module gbt_tx_frame_gen #(
    parameter int          FRAME_LEN   = 8,
    parameter logic [15:0] IDLE_WORD   = DEF_IDLE_WORD,
    parameter logic [15:0] FILL_WORD   = DEF_FILL_WORD,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LINK_RDY_ASYNC,
    input  logic        ENA_TEST,
    input  logic [15:0] DIN,
    input  logic        DIN_VLD,
    output logic        DIN_RDY,
    output logic [15:0] GBT_DATA_OUT,
    output logic        TEST_ACTIVE,
    output logic [7:0]  FRAME_CNT,
    output logic [7:0]  ABORT_CNT
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t      r_state;
    logic [15:0] r_data;
    logic [15:0] r_csum;
    logic [7:0]  r_idx;
    logic [7:0]  r_seq;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  r_abort_cnt;
    logic        r_test_active;

    logic        w_link_ok;
    logic        w_din_rdy;
    logic        w_xfer;
    logic        w_abort;

    gbt_link_sync #(
        .STAGES (SYNC_STAGES)
    ) u_link_sync (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_d     (LINK_RDY_ASYNC),
        .o_q     (w_link_ok)
    );

`ifdef GBT_TX_PRBS_EN
    logic [6:0]  r_lfsr;
    logic [22:0] w_prbs_entry;
    logic [22:0] w_prbs_next;
    assign w_prbs_entry = prbs7_adv16(PRBS7_SEED);
    assign w_prbs_next  = prbs7_adv16(r_lfsr);
`else
    logic [15:0] r_cnt;
`endif

    assign w_din_rdy = (r_state == ST_PAY) && w_link_ok;
    assign w_xfer    = DIN_VLD && w_din_rdy;
    assign w_abort   = !w_link_ok &&
                       ((r_state == ST_HDR) || (r_state == ST_PAY) || (r_state == ST_TRL));

    // Frame sequencing, registered output word and status counters
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= ST_IDLE;
            r_data        <= IDLE_WORD;
            r_csum        <= 16'h0000;
            r_idx         <= 8'd0;
            r_seq         <= 8'd0;
            r_frame_cnt   <= 8'd0;
            r_abort_cnt   <= 8'd0;
            r_test_active <= 1'b0;
`ifdef GBT_TX_PRBS_EN
            r_lfsr        <= PRBS7_SEED;
`else
            r_cnt         <= 16'h0000;
`endif
        end else if (w_abort) begin
            // seq is left alone so the retried frame carries the same header
            r_state <= ST_IDLE;
            r_data  <= IDLE_WORD;
            if (r_abort_cnt != 8'hFF) begin
                r_abort_cnt <= r_abort_cnt + 8'd1;
            end else begin
                r_abort_cnt <= r_abort_cnt;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ENA_TEST) begin
                        r_state       <= ST_TEST;
                        r_test_active <= 1'b1;
`ifdef GBT_TX_PRBS_EN
                        r_data        <= w_prbs_entry[15:0];
                        r_lfsr        <= w_prbs_entry[22:16];
`else
                        r_data        <= 16'h0000;
                        r_cnt         <= 16'h0001;
`endif
                    end else begin
                        r_data <= IDLE_WORD;
                        if (w_link_ok && DIN_VLD) begin
                            r_state <= ST_HDR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_HDR: begin
                    r_data  <= {HDR_MARK, r_seq};
                    r_idx   <= 8'd0;
                    r_csum  <= 16'h0000;
                    r_state <= ST_PAY;
                end
                ST_PAY: begin
                    if (w_xfer) begin
                        r_data <= DIN;
                        r_csum <= r_csum ^ DIN;
                        r_idx  <= r_idx + 8'd1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_TRL;
                        end else begin
                            r_state <= ST_PAY;
                        end
                    end else begin
                        r_data <= FILL_WORD;
                    end
                end
                ST_TRL: begin
                    r_data      <= r_csum;
                    r_seq       <= r_seq + 8'd1;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    r_state     <= ST_IDLE;
                end
                ST_TEST: begin
                    if (ENA_TEST) begin
`ifdef GBT_TX_PRBS_EN
                        r_data <= w_prbs_next[15:0];
                        r_lfsr <= w_prbs_next[22:16];
`else
                        r_data <= r_cnt;
                        r_cnt  <= r_cnt + 16'h0001;
`endif
                    end else begin
                        r_state       <= ST_IDLE;
                        r_test_active <= 1'b0;
                        r_data        <= IDLE_WORD;
`ifdef GBT_TX_PRBS_EN
                        r_lfsr        <= PRBS7_SEED;
`else
                        r_cnt         <= 16'h0000;
`endif
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_data        <= IDLE_WORD;
                    r_test_active <= 1'b0;
                end
            endcase
        end
    end

    assign DIN_RDY      = w_din_rdy;
    assign GBT_DATA_OUT = r_data;
    assign TEST_ACTIVE  = r_test_active;
    assign FRAME_CNT    = r_frame_cnt;
    assign ABORT_CNT    = r_abort_cnt;

endmodule

// File: tb/tb_gbt_tx_frame_gen.sv
// Self-checking bench for gbt_tx_frame_gen: directed scenarios with literal
// expectations plus a randomized run checked against a frame-level model.
module tb_gbt_tx_frame_gen;

    localparam int FL = 4;
    localparam int SS = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        LINK_RDY_ASYNC = 1'b0;
    logic        ENA_TEST = 1'b0;
    logic [15:0] DIN = 16'h0000;
    logic        DIN_VLD = 1'b0;
    logic        DIN_RDY;
    logic [15:0] GBT_DATA_OUT;
    logic        TEST_ACTIVE;
    logic [7:0]  FRAME_CNT;
    logic [7:0]  ABORT_CNT;

    gbt_tx_frame_gen #(
        .FRAME_LEN   (FL),
        .IDLE_WORD   (16'hBC50),
        .FILL_WORD   (16'hF7F7),
        .SYNC_STAGES (SS)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .LINK_RDY_ASYNC (LINK_RDY_ASYNC),
        .ENA_TEST       (ENA_TEST),
        .DIN            (DIN),
        .DIN_VLD        (DIN_VLD),
        .DIN_RDY        (DIN_RDY),
        .GBT_DATA_OUT   (GBT_DATA_OUT),
        .TEST_ACTIVE    (TEST_ACTIVE),
        .FRAME_CNT      (FRAME_CNT),
        .ABORT_CNT      (ABORT_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: 0 idle, 1 header due, 2 payload, 3 trailer due, 4 test
    int          m_mode;
    bit          m_ok;
    bit          lq[$];
    logic [15:0] m_out;
    logic [7:0]  m_seq, m_fc, m_ac;
    bit          m_act;
    logic [15:0] m_pay[$];
    int          m_pat;
    bit          ext[0:133];

    logic [15:0] cap[$];
    bit          cap_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Test word n counted from TEST entry; PRBS bits come from the recurrence b[i]=b[i-6]^b[i-7]
    function automatic logic [15:0] pat_word(input int n);
        logic [15:0] w;
`ifdef GBT_TX_PRBS_EN
        for (int j = 0; j < 16; j++) w[15-j] = ext[((16*n + j) % 127) + 7];
`else
        w = n[15:0];
`endif
        return w;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        lq = {};
        for (int i = 0; i < SS; i++) lq.push_back(1'b0);
        m_ok = 1'b0;
        m_out = 16'hBC50;
        m_seq = 8'd0; m_fc = 8'd0; m_ac = 8'd0;
        m_act = 1'b0;
        m_pay.delete();
        m_pat = 0;
    endtask

    task automatic model_edge();
        logic [15:0] x;
        if (!RST_N) begin
            model_reset();
            return;
        end
        if ((m_mode >= 1) && (m_mode <= 3) && !m_ok) begin
            m_mode = 0;
            m_out = 16'hBC50;
            if (m_ac != 8'd255) m_ac = m_ac + 8'd1;
        end else begin
            case (m_mode)
                0: begin
                    m_out = 16'hBC50;
                    if (ENA_TEST) begin
                        m_mode = 4; m_act = 1'b1; m_out = pat_word(0); m_pat = 1;
                    end else if (m_ok && DIN_VLD) begin
                        m_mode = 1;
                    end
                end
                1: begin
                    m_out = {8'hA5, m_seq};
                    m_pay.delete();
                    m_mode = 2;
                end
                2: begin
                    if (DIN_VLD) begin
                        m_out = DIN;
                        m_pay.push_back(DIN);
                        if (m_pay.size() == FL) m_mode = 3;
                    end else begin
                        m_out = 16'hF7F7;
                    end
                end
                3: begin
                    x = 16'h0000;
                    foreach (m_pay[i]) x = x ^ m_pay[i];
                    m_out = x;
                    m_seq = m_seq + 8'd1;
                    m_fc = m_fc + 8'd1;
                    m_mode = 0;
                end
                default: begin
                    if (ENA_TEST) begin
                        m_out = pat_word(m_pat);
                        m_pat++;
                    end else begin
                        m_mode = 0; m_act = 1'b0; m_out = 16'hBC50;
                    end
                end
            endcase
        end
        lq.push_back(LINK_RDY_ASYNC);
        void'(lq.pop_front());
        m_ok = lq[0];
    endtask

    task automatic compare();
        chk("data", {16'h0, GBT_DATA_OUT}, {16'h0, m_out});
        chk("din_rdy", {31'h0, DIN_RDY}, {31'h0, (m_mode == 2) && m_ok});
        chk("test_active", {31'h0, TEST_ACTIVE}, {31'h0, m_act});
        chk("frame_cnt", {24'h0, FRAME_CNT}, {24'h0, m_fc});
        chk("abort_cnt", {24'h0, ABORT_CNT}, {24'h0, m_ac});
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare();
        if (cap_en) cap.push_back(GBT_DATA_OUT);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        model_reset();
        compare();
        tick();
        RST_N = 1'b1;
    endtask

    // Sends payload words 1..FL, optionally pausing gap_len cycles after gap_pos words
    task automatic send_frame(input int gap_pos, input int gap_len);
        int  k;
        int  gap_left;
        bit  rdy_pre, vld_pre;
        k = 0;
        gap_left = gap_len;
        cap.delete();
        cap_en = 1'b1;
        DIN_VLD = 1'b1;
        DIN = 16'h0001;
        for (int c = 0; c < 16; c++) begin
            rdy_pre = DIN_RDY;
            vld_pre = DIN_VLD;
            tick();
            if (rdy_pre && vld_pre) k++;
            if (k >= FL) begin
                DIN_VLD = 1'b0;
            end else if (k == gap_pos && gap_left > 0) begin
                chk("gap_din_rdy", {31'h0, DIN_RDY}, 32'd1);
                DIN_VLD = 1'b0;
                gap_left--;
            end else begin
                DIN_VLD = 1'b1;
                DIN = 16'(k + 1);
            end
        end
        cap_en = 1'b0;
    endtask

    task automatic check_cap(input string nm, input logic [15:0] exp[$]);
        int s;
        s = -1;
        foreach (cap[i]) if (s < 0 && cap[i] != 16'hBC50) s = i;
        if (s < 0 || (s + exp.size()) > cap.size()) begin
            chk({nm, "_found"}, 32'd0, 32'd1);
        end else begin
            foreach (exp[j]) chk(nm, {16'h0, cap[s + j]}, {16'h0, exp[j]});
        end
    endtask

    initial begin
        logic [15:0] e2[$];
        logic [15:0] e3[$];
        int          n;
        bit          rdy_pre, vld_pre;
        int          k;

        for (int i = 0; i < 7; i++) ext[i] = 1'b1;
        for (int i = 0; i < 127; i++) ext[i + 7] = ext[i + 1] ^ ext[i];
        model_reset();

        // Reset held with link down and data offered
        DIN_VLD = 1'b1;
        @(negedge CLK);
        chk("rst_data", {16'h0, GBT_DATA_OUT}, 32'h0000BC50);
        chk("rst_rdy", {31'h0, DIN_RDY}, 32'd0);
        chk("rst_active", {31'h0, TEST_ACTIVE}, 32'd0);
        chk("rst_fcnt", {24'h0, FRAME_CNT}, 32'd0);
        chk("rst_acnt", {24'h0, ABORT_CNT}, 32'd0);
        tick();
        tick();
        DIN_VLD = 1'b0;
        RST_N = 1'b1;

        // Plain frame, then the following header carries seq 1
        LINK_RDY_ASYNC = 1'b1;
        repeat (SS + 1) tick();
        e2 = '{16'hA500, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004, 16'hBC50};
        send_frame(99, 0);
        check_cap("frame_seq", e2);
        chk("frame_cnt_1", {24'h0, FRAME_CNT}, 32'd1);
        send_frame(99, 0);
        e3 = '{16'hA501};
        check_cap("hdr_seq1", e3);

        // Frame with a two-cycle valid gap after the second word
        do_reset();
        repeat (SS + 1) tick();
        e3 = '{16'hA500, 16'h0001, 16'h0002, 16'hF7F7, 16'hF7F7, 16'h0003, 16'h0004, 16'h0004};
        send_frame(2, 2);
        check_cap("gap_seq", e3);

        // Link loss after two payload words
        do_reset();
        repeat (SS + 1) tick();
        DIN_VLD = 1'b1; DIN = 16'h0001; k = 0;
        for (int c = 0; c < 20 && k < 2; c++) begin
            rdy_pre = DIN_RDY; vld_pre = DIN_VLD;
            tick();
            if (rdy_pre && vld_pre) k++;
            DIN = 16'(k + 1);
        end
        LINK_RDY_ASYNC = 1'b0;
        DIN_VLD = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (GBT_DATA_OUT != 16'hBC50 && n < SS + 1);
        chk("drop_idle", {16'h0, GBT_DATA_OUT}, 32'h0000BC50);
        chk("drop_abort", {24'h0, ABORT_CNT}, 32'd1);
        chk("drop_frames", {24'h0, FRAME_CNT}, 32'd0);
        LINK_RDY_ASYNC = 1'b1;
        repeat (SS + 1) tick();
        send_frame(99, 0);
        e3 = '{16'hA500};
        check_cap("retry_hdr", e3);

        // Test-pattern mode
        do_reset();
        ENA_TEST = 1'b1;
        tick();
        chk("test_active_on", {31'h0, TEST_ACTIVE}, 32'd1);
`ifdef GBT_TX_PRBS_EN
        chk("prbs_first", {16'h0, GBT_DATA_OUT}, 32'h0000020C);
        for (int c = 2; c <= 260; c++) begin
            tick();
            chk("prbs_nonzero", {31'h0, GBT_DATA_OUT != 16'h0000}, 32'd1);
            if (c == 128) chk("prbs_period", {16'h0, GBT_DATA_OUT}, 32'h0000020C);
        end
`else
        chk("cnt_first", {16'h0, GBT_DATA_OUT}, 32'h00000000);
        tick();
        chk("cnt_second", {16'h0, GBT_DATA_OUT}, 32'h00000001);
        for (int c = 3; c <= 65537; c++) tick();
        chk("cnt_wrap", {16'h0, GBT_DATA_OUT}, 32'h00000000);
`endif
        ENA_TEST = 1'b0;
        tick();
        chk("test_exit_data", {16'h0, GBT_DATA_OUT}, 32'h0000BC50);
        chk("test_exit_active", {31'h0, TEST_ACTIVE}, 32'd0);

        // Randomized traffic with link drops, test requests and a mid-run reset
        do_reset();
        LINK_RDY_ASYNC = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(39, 0) == 0) LINK_RDY_ASYNC = ~LINK_RDY_ASYNC;
            if ($urandom_range(59, 0) == 0) ENA_TEST = ~ENA_TEST;
            DIN_VLD = ($urandom_range(3, 0) != 0);
            DIN = 16'($urandom);
            if (c == 1200) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
